// File: rtl/isp_pkg.sv
// Shared definitions for the raw ISP front-end window blocks.
// Holds the crop FSM encoding and the Bayer-phase alignment test.
package isp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CROP   = 2'd1,
        ST_BYPASS = 2'd2
    } crop_state_e;

    // An origin or size keeps the Bayer phase only when it is even.
    function automatic logic bayer_even(input logic [31:0] v);
        return ~v[0];
    endfunction

endpackage

// File: rtl/isp_sync_cnt.sv
// Frame-start detection plus saturating pixel/line position counters.
// Reusable by any window-based block (crop, AE/AWB statistics).
module isp_sync_cnt #(
    parameter int CW = 16
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          href_i,
    input  logic          vsync_i,
    output logic          fs_o,
    output logic [CW-1:0] pix_cnt_o,
    output logic [CW-1:0] line_cnt_o
);

    logic          prev_href_q, prev_vsync_q;
    logic [CW-1:0] pix_q, pix_d;
    logic [CW-1:0] line_q, line_d;
    logic          href_rise, line_end;
    logic [CW-1:0] pix_cur;

    assign fs_o      = prev_vsync_q & ~vsync_i;
    assign line_end  = prev_href_q & ~href_i;
    assign href_rise = href_i & ~prev_href_q;

    // Index of the pixel currently on the input; the first pixel of a line is 0.
    assign pix_cur    = href_rise ? '0 : pix_q;
    assign pix_cnt_o  = pix_cur;
    assign line_cnt_o = line_q;

    always_comb begin
        pix_d = pix_q;
        if (href_i)
            pix_d = (pix_cur == '1) ? pix_cur : pix_cur + 1'b1;
    end

    // Frame start takes priority over a coincident line end.
    always_comb begin
        line_d = line_q;
        if (fs_o)
            line_d = '0;
        else if (line_end && line_q != '1)
            line_d = line_q + 1'b1;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            prev_href_q  <= 1'b0;
            prev_vsync_q <= 1'b0;
            pix_q        <= '0;
            line_q       <= '0;
        end else begin
            prev_href_q  <= href_i;
            prev_vsync_q <= vsync_i;
            pix_q        <= pix_d;
            line_q       <= line_d;
        end
    end

endmodule

// File: rtl/isp_crop_win.sv
// Programmable Bayer-domain crop window with frame-start shadowed config.
// Invalid windows fall back to pass-through and raise cfg_err for the frame.
module isp_crop_win
    import isp_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960,
    parameter int CW     = 16
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [CW-1:0]   crop_x,
    input  logic [CW-1:0]   crop_y,
    input  logic [CW-1:0]   crop_w,
    input  logic [CW-1:0]   crop_h,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_data,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_data,
    output logic            cfg_err
);

    logic          fs;
    logic [CW-1:0] pix_cnt, line_cnt;

    isp_sync_cnt #(.CW(CW)) u_sync (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .href_i     (in_href),
        .vsync_i    (in_vsync),
        .fs_o       (fs),
        .pix_cnt_o  (pix_cnt),
        .line_cnt_o (line_cnt)
    );

    // Window check on the live inputs, with one guard bit so sums cannot wrap.
    logic [CW:0] x_end_in, y_end_in;
    logic        cfg_valid;

    assign x_end_in = {1'b0, crop_x} + {1'b0, crop_w};
    assign y_end_in = {1'b0, crop_y} + {1'b0, crop_h};

    assign cfg_valid = bayer_even(32'(crop_x)) & bayer_even(32'(crop_y)) &
                       bayer_even(32'(crop_w)) & bayer_even(32'(crop_h)) &
                       (crop_w != '0) & (crop_h != '0) &
                       (x_end_in <= (CW+1)'(WIDTH)) &
                       (y_end_in <= (CW+1)'(HEIGHT));

    // Shadow window; the enable half of the config lives in the FSM state.
    logic [CW-1:0] sx_q, sy_q, sw_q, sh_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q <= '0;
            sy_q <= '0;
            sw_q <= '0;
            sh_q <= '0;
        end else if (fs) begin
            sx_q <= crop_x;
            sy_q <= crop_y;
            sw_q <= crop_w;
            sh_q <= crop_h;
        end
    end

    logic [CW:0] x_end_q, y_end_q;
    logic        inwin;

    assign x_end_q = {1'b0, sx_q} + {1'b0, sw_q};
    assign y_end_q = {1'b0, sy_q} + {1'b0, sh_q};

    assign inwin = ({1'b0, pix_cnt}  >= {1'b0, sx_q}) && ({1'b0, pix_cnt}  < x_end_q) &&
                   ({1'b0, line_cnt} >= {1'b0, sy_q}) && ({1'b0, line_cnt} < y_end_q);

    crop_state_e state_q, state_d;
    logic        cfg_err_q, cfg_err_d;
    logic        href_d;

    always_comb begin
        state_d   = state_q;
        cfg_err_d = cfg_err_q;
        href_d    = 1'b0;
        case (state_q)
            ST_CROP:   href_d = in_href & inwin;
            ST_BYPASS: href_d = in_href;
            default:   href_d = 1'b0;
        endcase
        if (fs) begin
            state_d   = (enable && cfg_valid) ? ST_CROP : ST_BYPASS;
            cfg_err_d = enable & ~cfg_valid;
        end
    end

    logic            out_href_q, out_vsync_q;
    logic [BITS-1:0] out_data_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cfg_err_q   <= 1'b0;
            out_href_q  <= 1'b0;
            out_vsync_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cfg_err_q   <= cfg_err_d;
            out_href_q  <= href_d;
            out_vsync_q <= in_vsync;
            out_data_q  <= href_d ? in_data : '0;
        end
    end

    assign out_href  = out_href_q;
    assign out_vsync = out_vsync_q;
    assign out_data  = out_data_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_isp_crop_win.sv
// Randomized-data bench for isp_crop_win against a row/column window model.
module tb_isp_crop_win;

    localparam int BITS   = 8;
    localparam int WIDTH  = 16;
    localparam int HEIGHT = 8;
    localparam int CW     = 16;

    logic            pclk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic [CW-1:0]   crop_x = '0, crop_y = '0, crop_w = '0, crop_h = '0;
    logic            in_href = 1'b0, in_vsync = 1'b0;
    logic [BITS-1:0] in_data = '0;
    logic            out_href, out_vsync, cfg_err;
    logic [BITS-1:0] out_data;

    isp_crop_win #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CW(CW)) dut (
        .pclk(pclk), .rst_n(rst_n), .enable(enable),
        .crop_x(crop_x), .crop_y(crop_y), .crop_w(crop_w), .crop_h(crop_h),
        .in_href(in_href), .in_vsync(in_vsync), .in_data(in_data),
        .out_href(out_href), .out_vsync(out_vsync), .out_data(out_data),
        .cfg_err(cfg_err)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    // Model: 0 = no output yet, 1 = cropping, 2 = pass-through.
    int m_mode = 0;
    bit m_err  = 0;
    bit m_pv   = 0;
    int m_x, m_y, m_w, m_h;
    int fr_pix, fr_lines;
    bit prev_oh = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit win_ok(input int x, input int y, input int w, input int h);
        return (x % 2 == 0) && (y % 2 == 0) && (w % 2 == 0) && (h % 2 == 0) &&
               (w != 0) && (h != 0) && (x + w <= WIDTH) && (y + h <= HEIGHT);
    endfunction

    // One pclk with the given inputs; outputs checked #1 after the edge.
    task automatic step(input bit h, input bit v, input int row, input int col);
        logic [BITS-1:0] d;
        bit              eh;
        bit              ok;
        d = BITS'($urandom);
        in_href  = h;
        in_vsync = v;
        in_data  = d;
        eh = h && (m_mode == 2 ||
                   (m_mode == 1 && col >= m_x && col < m_x + m_w &&
                                   row >= m_y && row < m_y + m_h));
        if (m_pv && !v) begin
            m_x = int'(crop_x); m_y = int'(crop_y);
            m_w = int'(crop_w); m_h = int'(crop_h);
            ok = win_ok(m_x, m_y, m_w, m_h);
            m_mode = (enable && ok) ? 1 : 2;
            m_err  = enable && !ok;
        end
        m_pv = v;
        @(posedge pclk);
        #1;
        check("href",    32'(out_href),  32'(eh));
        check("data",    32'(out_data),  eh ? 32'(d) : 32'd0);
        check("vsync",   32'(out_vsync), 32'(v));
        check("cfg_err", 32'(cfg_err),   32'(m_err));
        if (out_href) fr_pix++;
        if (out_href && !prev_oh) fr_lines++;
        prev_oh = out_href;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_href",  32'(out_href),  32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_vsync", 32'(out_vsync), 32'd0);
        check("rst_err",   32'(cfg_err),   32'd0);
        m_mode = 0; m_err = 0; m_pv = 0; prev_oh = 0;
        fr_pix = 0; fr_lines = 0;
        in_href = 1'b1;
        repeat (2) begin
            in_data = BITS'($urandom);
            @(posedge pclk);
            #1;
            check("rst_hold_href", 32'(out_href), 32'd0);
            check("rst_hold_data", 32'(out_data), 32'd0);
        end
        rst_n = 1'b1;
    endtask

    task automatic frame(input string tag, input int nlines, input bit with_vs,
                         input int chg_line, input int chg_x, input int rst_line);
        int exp_pix, exp_lines;
        fr_pix = 0;
        fr_lines = 0;
        if (with_vs) begin
            repeat (4) step(0, 1, -1, -1);
        end
        repeat (3) step(0, 0, -1, -1);
        for (int r = 0; r < nlines; r++) begin
            if (r == chg_line) crop_x = CW'(chg_x);
            for (int c = 0; c < WIDTH; c++) begin
                if (r == rst_line && c == WIDTH / 2) do_reset();
                step(1, 0, r, c);
            end
            repeat (4) step(0, 0, -1, -1);
        end
        case (m_mode)
            1: begin exp_pix = m_w * m_h; exp_lines = m_h; end
            2: begin exp_pix = nlines * WIDTH; exp_lines = nlines; end
            default: begin exp_pix = 0; exp_lines = 0; end
        endcase
        check({tag, "_pix"},   32'(fr_pix),   32'(exp_pix));
        check({tag, "_lines"}, 32'(fr_lines), 32'(exp_lines));
    endtask

    task automatic set_cfg(input bit en, input int x, input int y, input int w, input int h);
        enable = en;
        crop_x = CW'(x); crop_y = CW'(y); crop_w = CW'(w); crop_h = CW'(h);
    endtask

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check("reset_href",  32'(out_href),  32'd0);
        check("reset_vsync", 32'(out_vsync), 32'd0);
        check("reset_data",  32'(out_data),  32'd0);
        check("reset_err",   32'(cfg_err),   32'd0);
        rst_n = 1'b1;

        // Stimulus starts mid-frame: nothing may come out before the first fs.
        set_cfg(1, 4, 2, 8, 4);
        frame("midstart", 5, 0, -1, 0, -1);

        frame("crop1", HEIGHT, 1, -1, 0, -1);
        frame("crop2_tall", HEIGHT + 1, 1, -1, 0, -1);

        set_cfg(1, 3, 2, 8, 4);
        frame("odd_x", HEIGHT, 1, -1, 0, -1);

        set_cfg(1, 10, 2, 8, 4);
        frame("oob", HEIGHT, 1, -1, 0, -1);

        set_cfg(1, 8, 2, 8, 4);
        frame("edge", HEIGHT, 1, -1, 0, -1);

        set_cfg(1, 4, 2, 8, 4);
        frame("midchg", HEIGHT, 1, 3, 6, -1);
        frame("after_chg", HEIGHT, 1, -1, 0, -1);

        set_cfg(1, 2, 0, 6, 6);
        frame("rst_frame", HEIGHT, 1, -1, 0, 4);
        frame("post_rst", HEIGHT, 1, -1, 0, -1);

        set_cfg(0, 4, 2, 8, 4);
        frame("disabled", HEIGHT, 1, -1, 0, -1);

        for (int i = 0; i < 5; i++) begin
            set_cfg($urandom_range(0, 3) != 0,
                    $urandom_range(0, 12), $urandom_range(0, 6),
                    $urandom_range(0, 12), $urandom_range(0, 8));
            frame("rand", HEIGHT, 1, -1, 0, -1);
        end

        repeat (2) step(0, 1, -1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/isp_crop_win.md
# isp_crop_win

Programmable Bayer-domain crop window for the raw ISP front end, sitting between the sensor/DPC stage and black-level correction. Unlike the fixed centre crop, it takes an arbitrary window origin and size per frame. Configuration is shadow-latched at frame start, so it is never applied mid-frame. A Bayer-phase and bounds check runs on every frame, and an invalid window falls back to pass-through with an error flag. Pixel, href and vsync outputs are all registered with a uniform 1-cycle latency.

## Interface
- BITS, 8, raw pixel width
- WIDTH, 1280, input active width in pixels
- HEIGHT, 960, input active height in lines
- CW, 16, width of counters and configuration fields
- pclk  in  1  pixel clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock pclk
- enable  in  1  crop enable; low selects pass-through; sampled at frame start
- crop_x  in  CW  window left column (first kept pixel)
- crop_y  in  CW  window top line
- crop_w  in  CW  window width in pixels
- crop_h  in  CW  window height in lines
- in_href  in  1  line-valid, high during active pixels
- in_vsync  in  1  frame sync, high during vertical blanking
- in_data  in  BITS  raw pixel
- out_href  out  1  cropped line-valid
- out_vsync  out  1  in_vsync delayed 1 cycle
- out_data  out  BITS  pixel, forced to 0 when out_href=0
- cfg_err  out  1  high for the whole frame when the latched window is invalid

## Operation
- **Frame start (fs)**: prev_vsync & ~in_vsync, where prev_vsync is in_vsync registered. Line end: prev_href & ~in_href.
- **Shadow latch**: at fs, enable, crop_x, crop_y, crop_w and crop_h are copied into shadow registers. Input changes at any other time have no effect.
- **Validity**, evaluated at fs on the input values, in CW+1-bit arithmetic:
  - crop_x[0]=0, crop_y[0]=0, crop_w[0]=0, crop_h[0]=0 (Bayer phase preserved)
  - crop_w≠0, crop_h≠0
  - crop_x+crop_w ≤ WIDTH, crop_y+crop_h ≤ HEIGHT
- **pix_cnt**: cleared on the rising edge of in_href (first pixel = 0). Increments on each in_href=1 cycle and saturates at 2^CW−1.
- **line_cnt**: cleared at fs. Increments at line end and saturates. If fs and line end coincide, fs wins (line_cnt=0).
- **inwin**: pix_cnt ∈ [sx, sx+sw) && line_cnt ∈ [sy, sy+sh), using shadow values and CW+1-bit sums.
- **FSM** (reset state IDLE):
  - IDLE: out_href=0, so no partial frame is emitted after reset. At fs, go to CROP if shadow enable && valid; go to BYPASS if !enable; go to BYPASS with cfg_err=1 if enable && !valid.
  - CROP: out_href = registered(in_href && inwin).
  - BYPASS: out_href = registered(in_href).
  - Every fs re-evaluates the transition from CROP or BYPASS using the same rules.
- **cfg_err**: updated only at fs and held until the next fs.
- **Input lines beyond HEIGHT** are counted normally and are excluded by inwin.

## Timing
- **Reset values**: out_href=0, out_vsync=0, out_data=0, cfg_err=0. All counters and shadows are 0 and the state is IDLE.
- **Latency**: in_data, in_href and in_vsync to outputs is exactly 1 pclk in all states.
- **First-pixel alignment**: the pixel at pix_cnt=sx of line sy appears on out_data 1 cycle after it is presented on in_data.
- **New configuration**: takes effect on the first line of the frame whose fs samples it. The state change and cfg_err update are visible in the cycle after fs.
- **Asynchronous reset mid-frame**: outputs go to their reset values immediately. The block stays in IDLE until the next fs, and the remainder of the current frame produces no out_href.
- **No back-pressure**: there is no stall or handshake; the block is a streaming pass with 1 register stage.

## Structure
- Shared package isp_pkg holds:
  - the Bayer-alignment check function (even-value test)
  - the FSM state encoding (IDLE, CROP, BYPASS)
- One natural sub-module, isp_sync_cnt: edge detection of href/vsync plus the saturating pix_cnt/line_cnt. It is reusable by other window-based blocks such as AE/AWB statistics.

## Test plan
- **Valid crop.** WIDTH=16, HEIGHT=8, x=4, y=2, w=8, h=4, enable=1, two frames.
  - Expected: 4 out_href lines of 8 pixels each.
  - Expected: first out pixel equals input (row 2, col 4), output 1 cycle later; cfg_err=0.
- **Odd origin.** x=3 latched at fs.
  - Expected: BYPASS for that frame: 8 lines × 16 pixels passed through 1 cycle late; cfg_err=1 for the whole frame.
- **Out of bounds.** x=10, w=8 (sum 18 > 16).
  - Expected: BYPASS and cfg_err=1.
  - Then x=8, w=8 (sum exactly 16) on the next frame: CROP, last column included.
- **Mid-frame config change.** Change crop_x from 4 to 6 at line 3.
  - Expected: current frame still uses x=4; the next frame uses x=6.
- **Reset sequencing.** Start stimulus mid-frame after reset release, then assert rst_n low mid-line in a later frame.
  - Expected: no out_href until the first fs.
  - Expected: all outputs 0 during reset; IDLE until the next fs.
- **enable=0.** Expected: exact 1-cycle delayed copy of in_href/in_data/in_vsync; cfg_err=0.
